fetch_queue: RTL
================

Name: fetch_queue

Overview:
- Instruction queue between instruction-memory fetch and the dual-issue dependency check stage.
- Accepts up to two fetched instructions per cycle, each with its PC and 2-bit predictor state.
- Presents the two oldest instructions as the inst1/inst2 pair and retires 0, 1 or 2 per cycle as the check stage directs: 0 on stall, 1 on dependency split, 2 on dual issue.
- Flushed on branch mispredict.

Parameters:
- DEPTH, 8, queue capacity in single instructions; power of two, at least 4.
- PCW, 13, PC width in bits.

Ports:
- CLK  input  1  clock, rising edge.
- NRST  input  1  asynchronous active-low reset.
- push_valid  input  1  fetch offers slot 1 this cycle.
- push_valid2  input  1  fetch also offers slot 2. Ignored unless push_valid. Low when slot 1 hit the branch cache (hit_predict1) or the fetch is odd-aligned.
- push_pc1, push_pc2  input  PCW each  PCs of fetch slots 1 and 2.
- push_inst1, push_inst2  input  32 each  instructions of fetch slots 1 and 2.
- push_state1, push_state2  input  2 each  predictor states of fetch slots 1 and 2.
- push_ready  output  1  queue can take two entries this cycle.
- pop_cnt  input  2  number of head entries consumed this cycle (0, 1 or 2; value 3 is treated as 2).
- flush  input  1  discard all entries (mispredict).
- pc1_out, pc2_out  output  PCW each  PCs of head and head+1.
- inst1_out, inst2_out  output  32 each  instructions of head and head+1.
- state1_out, state2_out  output  2 each  predictor states of head and head+1.
- valid_cnt  output  2  number of valid output slots, min(count, 2).

Behaviour:
- Storage: circular buffer of DEPTH entries {pc, inst, state}. Read pointer rd_ptr and write pointer wr_ptr are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
- Reset (NRST low, asynchronous): rd_ptr=0, wr_ptr=0, count=0. The storage array need not be reset. All pair outputs read 0; valid_cnt=0; push_ready=1.
- Outputs are combinational from registered state:
  - Slot 1 = entry[rd_ptr] if count>=1, else all-zero.
  - Slot 2 = entry[rd_ptr+1] if count>=2, else all-zero.
  - inst=0 is the bubble encoding; the check stage treats it as no instruction.
- push_ready = (count <= DEPTH-2). It is computed from the current count only, not from the same-cycle pop.
- Push amount n_push = push_valid & push_ready ? (push_valid2 ? 2 : 1) : 0.
  - Slot 1 is written at wr_ptr; slot 2 at wr_ptr+1.
  - If push_ready=0 the offer is ignored. Fetch holds the same pair and retries.
- Pop amount n_pop = min(pop_cnt clamped to 2, count). Over-pop is silently clamped; no underflow.
- Per cycle, when flush=0: rd_ptr += n_pop; wr_ptr += n_push; count += n_push - n_pop.
- Latency: a pushed entry appears on the outputs the cycle after it is written. There is no same-cycle bypass from push to output.
- Simultaneous push and pop are both applied in the same cycle. The count stays within 0..DEPTH by construction.
- flush=1 has priority over push and pop: rd_ptr=wr_ptr=0, count=0, and the same-cycle push is discarded. Next cycle the outputs are zero and push_ready=1.
- Order is strict FIFO. After a pop of 1, the old slot 2 becomes the new slot 1. This pairs with the check stage carrying inst2 forward on a dependency.
- Wrap-around: pointer increments wrap modulo DEPTH. A 2-entry push or read starting at index DEPTH-1 uses index 0 for its second entry.
- Reset asserted mid-operation clears the queue immediately, independent of CLK.

Test Plan:
- Reset then idle -> valid_cnt=0, inst1_out=inst2_out=0, push_ready=1.
- Push pair (pc 0x000/0x004, inst A/B) with pop_cnt=0; next cycle pop_cnt=2 -> the cycle after push shows pc1_out=0x000, inst1_out=A, pc2_out=0x004, inst2_out=B, valid_cnt=2; after the pop, count=0.
- Push A,B then C,D; pop_cnt=1 -> outputs become B,C; then pop_cnt=2 -> outputs D,0 with valid_cnt=1.
- Push with push_valid2=0 (branch-cache hit) -> only slot 1 is stored; count increases by 1 and slot 2 data is never seen.
- DEPTH=8, fill to count=7 with pop_cnt=0 -> push_ready=0 and the offered pair is not written. Pop 1 -> count=6 and push_ready=1. Keep streaming push 2 / pop 2 across index 7->0 -> order is preserved.
- With count=5, assert flush together with push_valid and pop_cnt=2 -> next cycle count=0, outputs zero, and the pushed pair is absent. pop_cnt=2 with count=1 -> count=0, with no underflow.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction fetch queue: circular buffer taking up to two fetched instructions per cycle
// and presenting the two oldest as an issue pair, retiring 0/1/2 per cycle or flushing.
module fetch_queue #(
    parameter int DEPTH = 8,
    parameter int PCW   = 13
) (
    input  logic           CLK,
    input  logic           NRST,
    input  logic           push_valid,
    input  logic           push_valid2,
    input  logic [PCW-1:0] push_pc1,
    input  logic [PCW-1:0] push_pc2,
    input  logic [31:0]    push_inst1,
    input  logic [31:0]    push_inst2,
    input  logic [1:0]     push_state1,
    input  logic [1:0]     push_state2,
    output logic           push_ready,
    input  logic [1:0]     pop_cnt,
    input  logic           flush,
    output logic [PCW-1:0] pc1_out,
    output logic [PCW-1:0] pc2_out,
    output logic [31:0]    inst1_out,
    output logic [31:0]    inst2_out,
    output logic [1:0]     state1_out,
    output logic [1:0]     state2_out,
    output logic [1:0]     valid_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 2);

    logic [PCW-1:0] mem_pc    [DEPTH];
    logic [31:0]    mem_inst  [DEPTH];
    logic [1:0]     mem_state [DEPTH];

    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr_nxt1;
    logic [AW-1:0] wr_ptr_nxt1;
    logic [CW-1:0] count;

    logic [1:0] pop_req;
    logic [1:0] n_pop;
    logic [1:0] n_push;
    logic       has1;
    logic       has2;

    // Second entry of a pair wraps naturally because DEPTH is a power of two.
    assign rd_ptr_nxt1 = rd_ptr + AW'(1);
    assign wr_ptr_nxt1 = wr_ptr + AW'(1);

    assign push_ready = (count <= READY_MAX);
    assign has1       = (count != '0);
    assign has2       = (count >= CW'(2));

    always_comb begin
        pop_req = pop_cnt[1] ? 2'd2 : pop_cnt;
    end

    // Over-pop is clamped to what the queue actually holds.
    always_comb begin
        n_pop = pop_req;
        if (count == '0) begin
            n_pop = 2'd0;
        end else if (count == CW'(1) && pop_req == 2'd2) begin
            n_pop = 2'd1;
        end
    end

    always_comb begin
        n_push = 2'd0;
        if (push_valid && push_ready) begin
            n_push = push_valid2 ? 2'd2 : 2'd1;
        end
    end

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + AW'(n_pop);
            wr_ptr <= wr_ptr + AW'(n_push);
            count  <= count + CW'(n_push) - CW'(n_pop);
        end
    end

    // Storage is data only and carries no reset; a flush drops the same-cycle push.
    always_ff @(posedge CLK) begin
        if (!flush && n_push != 2'd0) begin
            mem_pc[wr_ptr]    <= push_pc1;
            mem_inst[wr_ptr]  <= push_inst1;
            mem_state[wr_ptr] <= push_state1;
            if (n_push == 2'd2) begin
                mem_pc[wr_ptr_nxt1]    <= push_pc2;
                mem_inst[wr_ptr_nxt1]  <= push_inst2;
                mem_state[wr_ptr_nxt1] <= push_state2;
            end
        end
    end

    // Empty slots read as all-zero, which the check stage sees as a bubble.
    always_comb begin
        pc1_out    = has1 ? mem_pc[rd_ptr]    : '0;
        inst1_out  = has1 ? mem_inst[rd_ptr]  : '0;
        state1_out = has1 ? mem_state[rd_ptr] : '0;
        pc2_out    = has2 ? mem_pc[rd_ptr_nxt1]    : '0;
        inst2_out  = has2 ? mem_inst[rd_ptr_nxt1]  : '0;
        state2_out = has2 ? mem_state[rd_ptr_nxt1] : '0;
        valid_cnt  = has2 ? 2'd2 : count[1:0];
    end

endmodule
